// File: rtl/serial_digit_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encodings, counter sizing
// helper and the operand-width legality macro.
`define SDA_WIDTH_OK(W, D) (((D) >= 1) && ((D) <= (W)) && (((W) % (D)) == 0))

package serial_digit_adder_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((32'sd1 << r) < n) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_digit_adder_if.sv
// Request/result bundle between a controlling FSM (master) and the adder (slave).
interface serial_digit_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (output start, sub, a, b, c_in,
                  input  busy, done, sum, c_out, ovf);
  modport slave  (input  start, sub, a, b, c_in,
                  output busy, done, sum, c_out, ovf);
endinterface

// File: rtl/serial_digit_adder_slice.sv
// DIGIT-bit ripple-carry slice; also exposes the carry into its top bit so the
// caller can form signed overflow on the final digit.
module serial_digit_adder_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             c_out_o,
  output logic             c_msb_in_o
);

  logic [DIGIT:0] chain_s;

  // Full-adder chain, LSB to MSB.
  always_comb begin
    chain_s    = '0;
    chain_s[0] = c_i;
    sum_o      = '0;
    for (int i = 0; i < DIGIT; i++) begin
      sum_o[i]       = a_i[i] ^ b_i[i] ^ chain_s[i];
      chain_s[i + 1] = (a_i[i] & b_i[i]) | (chain_s[i] & (a_i[i] ^ b_i[i]));
    end
    c_out_o    = chain_s[DIGIT];
    c_msb_in_o = chain_s[DIGIT-1];
  end

endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle adder/subtractor: one DIGIT-bit slice reused N = WIDTH/DIGIT times,
// LSB digit first, behind a start/busy/done handshake.
module serial_digit_adder
  import serial_digit_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_digit_adder_if.slave  bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = clog2_min1(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!`SDA_WIDTH_OK(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("serial_digit_adder: WIDTH must be a positive multiple of DIGIT");
  end

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, sum_q, sum_d;
  logic             carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [DIGIT-1:0] slice_sum_s;
  logic             slice_co_s, slice_cmsb_s;
  logic [WIDTH-1:0] sh_shift_s;

  serial_digit_adder_slice #(.DIGIT(DIGIT)) u_slice (
    .a_i        (a_q[DIGIT-1:0]),
    .b_i        (b_q[DIGIT-1:0]),
    .c_i        (carry_q),
    .sum_o      (slice_sum_s),
    .c_out_o    (slice_co_s),
    .c_msb_in_o (slice_cmsb_s)
  );

  // Each new digit enters at the top so the LSB digit ends up at bit 0.
  if (DIGIT == WIDTH) begin : g_single
    assign sh_shift_s = slice_sum_s;
  end else begin : g_multi
    assign sh_shift_s = {slice_sum_s, sh_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sh_d    = sh_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.c_in;
          cnt_d   = '0;
          sum_d   = '0;
          c_out_d = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = slice_co_s;
        sh_d    = sh_shift_s;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = sh_shift_s;
          c_out_d = slice_co_s;
          ovf_d   = slice_co_s ^ slice_cmsb_s;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sh_q    <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sh_q    <= sh_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Directed vector table plus handshake corner sequences on WIDTH=8/DIGIT=2, and a
// random sweep of DIGIT=8 and DIGIT=1 against a behavioural reference.
module tb_serial_digit_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_digit_adder_if #(.WIDTH(8)) if2 ();
  serial_digit_adder_if #(.WIDTH(8)) if8 ();
  serial_digit_adder_if #(.WIDTH(8)) if1 ();

  serial_digit_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  serial_digit_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_digit_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       sub;
    logic [7:0] sum;
    logic       c_out;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called #1 after an edge; returns results, edges-to-done and busy-cycle count.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sb, output logic [7:0] s, output logic co,
                       output logic ov, output int lat, output int bcnt);
    if2.a = a; if2.b = b; if2.c_in = cin; if2.sub = sb; if2.start = 1'b1;
    @(posedge clk); #1;
    if2.start = 1'b0; if2.a = ~a; if2.b = 8'h5A; if2.c_in = ~cin; if2.sub = ~sb;
    lat = 0; s = 8'h00; co = 1'b0; ov = 1'b0;
    bcnt = if2.busy ? 1 : 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (if2.done) begin
        lat = c; s = if2.sum; co = if2.c_out; ov = if2.ovf;
        break;
      end
      if (if2.busy) bcnt++;
    end
  endtask

  initial begin
    logic [7:0] s, s1;
    logic       co, ov;
    int         lat, bcnt, ndone, c1, c2;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[2] = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h3C, 8'h42, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[8] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[9] = '{8'h7F, 8'h80, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1};

    if2.start = 1'b0; if2.sub = 1'b0; if2.a = 8'h00; if2.b = 8'h00; if2.c_in = 1'b0;
    if8.start = 1'b0; if8.sub = 1'b0; if8.a = 8'h00; if8.b = 8'h00; if8.c_in = 1'b0;
    if1.start = 1'b0; if1.sub = 1'b0; if1.a = 8'h00; if1.b = 8'h00; if1.c_in = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {if2.busy, if2.done, if2.sum, if2.c_out, if2.ovf}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].c_in, vecs[i].sub, s, co, ov, lat, bcnt);
      chk($sformatf("vec%0d_sum", i), s, vecs[i].sum);
      chk($sformatf("vec%0d_flags", i), {co, ov}, {vecs[i].c_out, vecs[i].ovf});
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, 4);
    end

    // start held again while busy must not launch a second operation
    if2.a = 8'h10; if2.b = 8'h20; if2.c_in = 1'b0; if2.sub = 1'b0; if2.start = 1'b1;
    @(posedge clk); #1;
    if2.start = 1'b0; if2.a = 8'h00;
    @(posedge clk); #1;
    if2.a = 8'hFF; if2.b = 8'hFF; if2.start = 1'b1;
    @(posedge clk); #1;
    if2.start = 1'b0;
    ndone = 0; s = 8'h00;
    for (int c = 0; c < 12; c++) begin
      if (if2.done) begin ndone++; s = if2.sum; end
      @(posedge clk); #1;
    end
    chk("busy_ignore_sum", s, 8'h30);
    chk("busy_ignore_done_count", ndone, 1);

    // back-to-back: second start issued in the done cycle
    if2.a = 8'h12; if2.b = 8'h34; if2.c_in = 1'b0; if2.sub = 1'b0; if2.start = 1'b1;
    @(posedge clk); #1;
    if2.start = 1'b0;
    c1 = -1; s1 = 8'h00;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (if2.done) begin c1 = cyc; s1 = if2.sum; break; end
    end
    if2.a = 8'hF0; if2.b = 8'h0F; if2.sub = 1'b1; if2.start = 1'b1;
    @(posedge clk); #1;
    if2.start = 1'b0;
    c2 = -100; s = 8'h00; co = 1'b0; ov = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (if2.done) begin c2 = cyc; s = if2.sum; co = if2.c_out; ov = if2.ovf; break; end
      @(posedge clk); #1;
    end
    chk("b2b_sum1", s1, 8'h46);
    chk("b2b_sum2", s, 8'hE1);
    chk("b2b_flags2", {co, ov}, 2'b10);
    chk("b2b_spacing", c2 - c1, 5);

    // reset in the middle of an operation
    if2.a = 8'h55; if2.b = 8'h11; if2.sub = 1'b0; if2.start = 1'b1;
    @(posedge clk); #1;
    if2.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midop_reset_outputs", {if2.busy, if2.done, if2.sum, if2.c_out, if2.ovf}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (if2.done) ndone++;
    end
    chk("midop_reset_no_done", ndone, 0);
    do_op(8'h21, 8'h13, 1'b1, 1'b0, s, co, ov, lat, bcnt);
    chk("after_reset_sum", s, 8'h35);
    chk("after_reset_latency", lat, 4);

    // random sweep on single-pass and bit-serial instances
    for (int n = 0; n < 1000; n++) begin
      logic [7:0] ra, rb, bb, s8, sb1;
      logic       rc, rs, co8, ov8, co1, ov1, got8, got1, eovf;
      logic [8:0] ref9;
      int         l8, l1;
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      bb   = rs ? ~rb : rb;
      ref9 = {1'b0, ra} + {1'b0, bb} + {8'h00, (rs ? 1'b1 : rc)};
      eovf = (ra[7] == bb[7]) && (ref9[7] != ra[7]);
      if8.a = ra; if8.b = rb; if8.c_in = rc; if8.sub = rs; if8.start = 1'b1;
      if1.a = ra; if1.b = rb; if1.c_in = rc; if1.sub = rs; if1.start = 1'b1;
      @(posedge clk); #1;
      if8.start = 1'b0; if1.start = 1'b0;
      if8.a = ~ra; if1.b = ~rb;
      got8 = 1'b0; got1 = 1'b0; l8 = 0; l1 = 0;
      s8 = 8'h00; sb1 = 8'h00; co8 = 1'b0; ov8 = 1'b0; co1 = 1'b0; ov1 = 1'b0;
      for (int c = 1; c <= 12; c++) begin
        @(posedge clk); #1;
        if (if8.done && !got8) begin got8 = 1'b1; l8 = c; s8 = if8.sum; co8 = if8.c_out; ov8 = if8.ovf; end
        if (if1.done && !got1) begin got1 = 1'b1; l1 = c; sb1 = if1.sum; co1 = if1.c_out; ov1 = if1.ovf; end
        if (got8 && got1) break;
      end
      chk($sformatf("d8_op%0d_result", n), {co8, ov8, s8}, {ref9[8], eovf, ref9[7:0]});
      chk($sformatf("d8_op%0d_latency", n), l8, 1);
      chk($sformatf("d1_op%0d_result", n), {co1, ov1, sb1}, {ref9[8], eovf, ref9[7:0]});
      chk($sformatf("d1_op%0d_latency", n), l1, 8);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
